// File: rtl/eq_output_capture_if.sv
// Sample-in / readout-out stream bundle for the equalizer output capture block.
// The slave modport is the capture block itself; master is whoever feeds and drains it.
interface eq_output_capture_if #(
    parameter int DATA_W = 16
);
    logic                     s_valid;
    logic signed [DATA_W-1:0] s_data;
    logic                     m_valid;
    logic signed [DATA_W-1:0] m_data;
    logic                     m_last;
    logic                     m_ready;

    modport master (
        output s_valid, s_data, m_ready,
        input  m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output m_valid, m_data, m_last
    );
endinterface

// File: rtl/eq_output_capture.sv
// Records a block of equalizer output samples into RAM on arm, tracking peak magnitude
// with optional decimation, then plays the block out over a valid/ready stream.
module eq_output_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DECIM  = 1
) (
    input  logic                clk,
    input  logic                rst,
    eq_output_capture_if.slave  bus,
    input  logic                arm,
    input  logic [ADDR_W:0]     capture_len,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   peak_abs
);

    localparam int                 DCNT_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DCNT_W-1:0]  DCNT_MAX = DCNT_W'(DECIM - 1);
    localparam logic [DCNT_W-1:0]  DCNT_ONE = 1;
    localparam logic [ADDR_W-1:0]  PTR_ONE  = 1;
    localparam logic [ADDR_W:0]    LEN_ONE  = 1;
    localparam logic [ADDR_W:0]    LEN_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0]  MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]  MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  len_last;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0]  rd_nxt;
    logic [DCNT_W-1:0]  decim_cnt;
    logic [DATA_W-1:0]  s_abs;
    logic               start;
    logic               sample_in;
    logic               wr_en;

    assign busy   = (state != IDLE);
    assign rd_nxt = rd_ptr + PTR_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        sample_in = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (arm && !abort) begin
                    start     = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bus.s_valid) begin
                    sample_in = 1'b1;
                    if (decim_cnt == '0) begin
                        wr_en = 1'b1;
                        if (wr_ptr == len_last) state_nxt = READOUT;
                    end
                end
            end
            READOUT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bus.m_valid && bus.m_ready && bus.m_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The most negative sample has no positive twin, so its magnitude saturates.
    always_comb begin
        if (bus.s_data == MIN_NEG) begin
            s_abs = MAX_POS;
        end else if (bus.s_data[DATA_W-1]) begin
            s_abs = -bus.s_data;
        end else begin
            s_abs = bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.s_data;
    end

    // m_valid rises one cycle after READOUT entry: the entry cycle fetches sample 0 straight
    // into the output register. Later samples are fetched on each accepted transfer, so the
    // register doubles as the stall holder and m_ready held high gives one sample per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_last    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            decim_cnt   <= '0;
            peak_abs    <= '0;
            done        <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
            bus.m_data  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                if (capture_len == '0 || capture_len > LEN_MAX) begin
                    len_last <= ADDR_W'(DEPTH - 1);
                end else begin
                    len_last <= ADDR_W'(capture_len - LEN_ONE);
                end
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                decim_cnt <= '0;
                peak_abs  <= '0;
            end
            if (sample_in) begin
                decim_cnt <= (decim_cnt == DCNT_MAX) ? '0 : decim_cnt + DCNT_ONE;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (s_abs > peak_abs) peak_abs <= s_abs;
            end
            if (state == READOUT && !abort) begin
                if (!bus.m_valid) begin
                    bus.m_data  <= mem[rd_ptr];
                    bus.m_valid <= 1'b1;
                    bus.m_last  <= (rd_ptr == len_last);
                end else if (bus.m_ready) begin
                    if (bus.m_last) begin
                        bus.m_valid <= 1'b0;
                        bus.m_last  <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        bus.m_data <= mem[rd_nxt];
                        bus.m_last <= (rd_nxt == len_last);
                        rd_ptr     <= rd_nxt;
                    end
                end
            end
            if (abort && state != IDLE) begin
                bus.m_valid <= 1'b0;
                bus.m_last  <= 1'b0;
            end
        end
    end

endmodule
